// File: rtl/csi2_packet_parser.sv
// csi2_packet_parser
//   Decodes CSI-2 packet headers from 2-lane byte-aligned data (sync byte
//   already stripped) and emits frame/line strobes, header metadata and a
//   16-bit payload stream with per-byte enables. One packet per HS burst.
//
// Ports
//   byte_clk, reset          : clock, synchronous active-high reset
//   in_valid                 : HS burst active, first cycle carries DI/WC_lo
//   lane0_byte, lane1_byte   : even / odd packet bytes
//   px_data, px_be           : payload word ([7:0] even byte) and byte enables
//   frame_start/frame_end/line_start/line_end : short-packet strobes (DT 0..3)
//   pkt_start, pkt_end       : long packet header accepted / last CRC byte consumed
//   vc, data_type, word_count: fields of the most recent header
//   line_count               : long packets accepted since last frame_start
//   pkt_err                  : oversize word count or burst aborted mid-packet
// All outputs are registered, one cycle after the input cycle that causes them.
module csi2_packet_parser #(
    parameter logic [15:0] MAX_WC = 16'd2560
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  lane0_byte,
    input  logic [7:0]  lane1_byte,
    output logic [15:0] px_data,
    output logic [1:0]  px_be,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        pkt_start,
    output logic        pkt_end,
    output logic [1:0]  vc,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic [15:0] line_count,
    output logic        pkt_err
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, WAIT_LP} state_t;

    state_t      state, state_nx;
    logic [7:0]  di_q, di_nx;
    logic [7:0]  wc_lo_q, wc_lo_nx;
    // Bytes still to consume in PAYLOAD (payload + 2 CRC); 17 bits so WC+2 never wraps.
    logic [16:0] rem, rem_nx;
    logic [16:0] left;
    logic [15:0] hdr_wc;

    logic [15:0] px_data_nx;
    logic [1:0]  px_be_nx;
    logic        fs_nx, fe_nx, ls_nx, le_nx, ps_nx, pe_nx, err_nx;
    logic [1:0]  vc_nx;
    logic [5:0]  dt_nx;
    logic [15:0] wc_nx, lc_nx;

    always_comb begin
        state_nx   = state;
        di_nx      = di_q;
        wc_lo_nx   = wc_lo_q;
        rem_nx     = rem;
        px_data_nx = '0;
        px_be_nx   = '0;
        fs_nx      = 1'b0;
        fe_nx      = 1'b0;
        ls_nx      = 1'b0;
        le_nx      = 1'b0;
        ps_nx      = 1'b0;
        pe_nx      = 1'b0;
        err_nx     = 1'b0;
        vc_nx      = vc;
        dt_nx      = data_type;
        wc_nx      = word_count;
        lc_nx      = line_count;
        hdr_wc     = {lane0_byte, wc_lo_q};
        // Payload bytes left this cycle = rem - 2, floored at 0.
        left       = (rem >= 17'd2) ? rem - 17'd2 : 17'd0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    di_nx    = lane0_byte;
                    wc_lo_nx = lane1_byte;
                    state_nx = HDR;
                end
            end
            HDR: begin
                if (!in_valid) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    vc_nx    = di_q[7:6];
                    dt_nx    = di_q[5:0];
                    wc_nx    = hdr_wc;
                    state_nx = WAIT_LP;
                    if (di_q[5:4] == 2'b00) begin
                        case (di_q[5:0])
                            6'h00: begin
                                fs_nx = 1'b1;
                                lc_nx = '0;
                            end
                            6'h01:   fe_nx = 1'b1;
                            6'h02:   ls_nx = 1'b1;
                            6'h03:   le_nx = 1'b1;
                            default: ;
                        endcase
                    end else if (hdr_wc > MAX_WC) begin
                        err_nx = 1'b1;
                    end else begin
                        ps_nx    = 1'b1;
                        lc_nx    = line_count + 16'd1;
                        rem_nx   = {1'b0, hdr_wc} + 17'd2;
                        state_nx = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!in_valid) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    px_be_nx[0] = (left != 17'd0);
                    px_be_nx[1] = (left >= 17'd2);
                    // CRC bytes sharing a word with payload are masked off.
                    px_data_nx  = {px_be_nx[1] ? lane1_byte : 8'h00,
                                   px_be_nx[0] ? lane0_byte : 8'h00};
                    rem_nx      = left;
                    if (rem <= 17'd2) begin
                        pe_nx    = 1'b1;
                        state_nx = WAIT_LP;
                    end
                end
            end
            WAIT_LP: begin
                if (!in_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge byte_clk) begin
        if (reset) begin
            state       <= IDLE;
            di_q        <= '0;
            wc_lo_q     <= '0;
            rem         <= '0;
            px_data     <= '0;
            px_be       <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            pkt_start   <= 1'b0;
            pkt_end     <= 1'b0;
            pkt_err     <= 1'b0;
            vc          <= '0;
            data_type   <= '0;
            word_count  <= '0;
            line_count  <= '0;
        end else begin
            state       <= state_nx;
            di_q        <= di_nx;
            wc_lo_q     <= wc_lo_nx;
            rem         <= rem_nx;
            px_data     <= px_data_nx;
            px_be       <= px_be_nx;
            frame_start <= fs_nx;
            frame_end   <= fe_nx;
            line_start  <= ls_nx;
            line_end    <= le_nx;
            pkt_start   <= ps_nx;
            pkt_end     <= pe_nx;
            pkt_err     <= err_nx;
            vc          <= vc_nx;
            data_type   <= dt_nx;
            word_count  <= wc_nx;
            line_count  <= lc_nx;
        end
    end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Scoreboard bench for csi2_packet_parser. A packet-level model turns each
// HS burst into the list of visible output events (with the cycle each must
// appear in); a monitor compares every DUT output event against that queue.
module tb_csi2_packet_parser;

    localparam logic [15:0] MAX_WC = 16'd2560;

    logic        byte_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  lane0_byte, lane1_byte;
    logic [15:0] px_data;
    logic [1:0]  px_be;
    logic        frame_start, frame_end, line_start, line_end;
    logic        pkt_start, pkt_end, pkt_err;
    logic [1:0]  vc;
    logic [5:0]  data_type;
    logic [15:0] word_count, line_count;

    csi2_packet_parser #(.MAX_WC(MAX_WC)) dut (
        .byte_clk(byte_clk), .reset(reset), .in_valid(in_valid),
        .lane0_byte(lane0_byte), .lane1_byte(lane1_byte),
        .px_data(px_data), .px_be(px_be),
        .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .line_end(line_end),
        .pkt_start(pkt_start), .pkt_end(pkt_end),
        .vc(vc), .data_type(data_type), .word_count(word_count),
        .line_count(line_count), .pkt_err(pkt_err)
    );

    always #5 byte_clk = ~byte_clk;

    typedef struct packed {
        logic [31:0] tag;
        logic [15:0] data;
        logic [1:0]  be;
        logic [6:0]  pl;   // {fs, fe, ls, le, ps, pe, err}
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [15:0] lc;
    } ev_t;

    ev_t        q[$];
    ev_t        act, exp_e;
    logic [7:0] bq[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    // model of the header-derived outputs
    logic [1:0]  m_vc;
    logic [5:0]  m_dt;
    logic [15:0] m_wc, m_lc;

    always @(posedge byte_clk) cyc <= cyc + 1;

    // monitor
    always @(negedge byte_clk) begin
        while (q.size() > 0 && q[0].tag < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL missed_event: expected %h at cycle %0d, not seen by %0d", q[0], q[0].tag, cyc);
            void'(q.pop_front());
        end
        act = '{tag: cyc, data: px_data, be: px_be,
                pl: {frame_start, frame_end, line_start, line_end, pkt_start, pkt_end, pkt_err},
                vc: vc, dt: data_type, wc: word_count, lc: line_count};
        if (act.be != 2'b00 || act.pl != 7'd0) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got %h at cycle %0d, none expected", act, cyc);
            end else begin
                exp_e = q.pop_front();
                if (act !== exp_e) begin
                    n_fail++;
                    $display("FAIL event: got %h, expected %h (cycle %0d)", act, exp_e, cyc);
                end
            end
        end
    end

    task automatic push_ev(input int tag, input int lim, input logic [15:0] d,
                           input logic [1:0] be, input logic [6:0] pl);
        ev_t e;
        if (tag < lim) begin
            e = '{tag: tag, data: d, be: be, pl: pl, vc: m_vc, dt: m_dt, wc: m_wc, lc: m_lc};
            q.push_back(e);
        end
    endtask

    function automatic int full_n(input logic [15:0] wc);
        return 2 + (int'(wc) + 3) / 2;
    endfunction

    task automatic gen(input logic [7:0] di, input logic [15:0] wc, input int n);
        bq.delete();
        bq.push_back(di);
        bq.push_back(wc[7:0]);
        if (n >= 2) begin
            bq.push_back(wc[15:8]);
            bq.push_back(8'($urandom));
            for (int i = 4; i < 2 * n; i++) bq.push_back(8'($urandom));
        end
    endtask

    // Drive bq as an n-cycle burst; rst_at >= 0 asserts reset on that burst cycle.
    task automatic send_burst(input int n, input int rst_at);
        int c, lim, j;
        logic [7:0]  di;
        logic [15:0] wc;
        logic [1:0]  be;
        logic [15:0] d;
        logic        pe;
        @(negedge byte_clk);
        c   = cyc;
        lim = (rst_at >= 0) ? c + rst_at + 1 : 32'h7fffffff;
        di  = bq[0];
        wc  = {bq[2 % bq.size()], bq[1]};
        if (n == 1) begin
            push_ev(c + 2, lim, 16'h0, 2'b00, 7'b0000001);
        end else begin
            m_vc = di[7:6]; m_dt = di[5:0]; m_wc = wc;
            if (di[5:0] < 6'h10) begin
                if (di[5:0] == 6'h00) m_lc = 16'h0;
                if (di[5:0] < 6'h04)
                    push_ev(c + 2, lim, 16'h0, 2'b00, 7'b1000000 >> di[5:0]);
            end else if (wc > MAX_WC) begin
                push_ev(c + 2, lim, 16'h0, 2'b00, 7'b0000001);
            end else begin
                m_lc = m_lc + 16'd1;
                push_ev(c + 2, lim, 16'h0, 2'b00, 7'b0000100);
                j = 0;
                forever begin
                    if (2 + j >= n) begin
                        push_ev(c + n + 1, lim, 16'h0, 2'b00, 7'b0000001);
                        break;
                    end
                    be = {(2 * j + 1) < int'(wc), (2 * j) < int'(wc)};
                    d  = {be[1] ? bq[5 + 2 * j] : 8'h00, be[0] ? bq[4 + 2 * j] : 8'h00};
                    pe = (2 * j) >= int'(wc);
                    push_ev(c + 3 + j, lim, d, be, {5'b0, pe, 1'b0});
                    if (pe) break;
                    j++;
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge byte_clk);
            in_valid   = 1'b1;
            lane0_byte = bq[2 * k];
            lane1_byte = bq[2 * k + 1];
            if (k == rst_at) begin
                reset = 1'b1;
                break;
            end
        end
        @(negedge byte_clk);
        if (rst_at >= 0) begin
            n_chk++;
            if ({px_data, px_be, frame_start, frame_end, line_start, line_end, pkt_start,
                 pkt_end, pkt_err, vc, data_type, word_count, line_count} !== 75'd0) begin
                n_fail++;
                $display("FAIL reset_mid_packet: outputs data=%h be=%b vc=%h dt=%h wc=%h lc=%h, required all 0",
                         px_data, px_be, vc, data_type, word_count, line_count);
            end
            m_vc = '0; m_dt = '0; m_wc = '0; m_lc = '0;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge byte_clk);
    endtask

    initial begin
        logic [7:0]  di;
        logic [15:0] wc;
        int          n, kind;
        reset = 1'b1; in_valid = 1'b0; lane0_byte = '0; lane1_byte = '0;
        m_vc = '0; m_dt = '0; m_wc = '0; m_lc = '0;
        repeat (3) @(negedge byte_clk);
        n_chk++;
        if ({px_data, px_be, frame_start, frame_end, line_start, line_end, pkt_start,
             pkt_end, pkt_err, vc, data_type, word_count, line_count} !== 75'd0) begin
            n_fail++;
            $display("FAIL reset_state: data=%h be=%b vc=%h dt=%h wc=%h lc=%h, required all 0",
                     px_data, px_be, vc, data_type, word_count, line_count);
        end
        reset = 1'b0;

        // short FS with WC=5
        gen(8'h00, 16'h0005, 2); send_burst(2, -1); idle(1);
        // long RAW8, WC=4
        gen(8'h2A, 16'd4, 5);
        bq[4] = 8'h11; bq[5] = 8'h22; bq[6] = 8'h33; bq[7] = 8'h44; bq[8] = 8'hAA; bq[9] = 8'hBB;
        send_burst(5, -1); idle(1);
        // odd WC=3
        gen(8'h2A, 16'd3, 5);
        bq[4] = 8'h11; bq[5] = 8'h22; bq[6] = 8'h33;
        send_burst(5, -1); idle(2);
        // oversize WC with trailing bytes, then FS
        gen(8'h2A, 16'h1000, 4); send_burst(4, -1); idle(1);
        gen(8'h00, 16'h0001, 2); send_burst(2, -1); idle(1);
        // abort after one payload cycle, then LS
        gen(8'h2B, 16'd8, 3); send_burst(3, -1); idle(1);
        gen(8'h02, 16'h0007, 2); send_burst(2, -1); idle(1);
        // abort inside header
        gen(8'h2A, 16'd8, 1); send_burst(1, -1); idle(1);
        // WC=0 long packet
        gen(8'h6C, 16'd0, 3); send_burst(3, -1); idle(1);
        // WC boundaries
        gen(8'h12, MAX_WC + 16'd1, 2); send_burst(2, -1); idle(1);
        gen(8'h12, MAX_WC, full_n(MAX_WC)); send_burst(full_n(MAX_WC), -1); idle(1);
        // reset mid-payload, then FE on VC3
        gen(8'h2A, 16'd8, 6); send_burst(6, 3); idle(1);
        gen(8'hC1, 16'h0002, 2); send_burst(2, -1); idle(1);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            di   = 8'($urandom);
            if (kind < 3) begin
                di[5:4] = 2'b00;
                if (kind == 0) di[3:2] = 2'b00;
                wc = 16'($urandom);
                n  = 2 + $urandom_range(0, 2);
            end else begin
                if (di[5:4] == 2'b00) di[4] = 1'b1;
                wc = 16'($urandom_range(0, 40));
                if (kind == 9) begin
                    wc = MAX_WC + 16'd1 + 16'($urandom_range(0, 100));
                    n  = 2 + $urandom_range(0, 2);
                end else if (kind == 8) begin
                    n = $urandom_range(1, full_n(wc) - 1);
                end else begin
                    n = full_n(wc) + $urandom_range(0, 2);
                end
            end
            gen(di, wc, n);
            send_burst(n, -1);
            idle($urandom_range(0, 2));
        end

        idle(5);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d events left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/csi2_packet_parser.md
# csi2_packet_parser

Downstream of the 2-lane MIPI receiver, in the `byte_clk` domain. Takes byte-aligned lane data (sync byte already stripped) and decodes CSI-2 packet headers. Emits frame and line strobes, packet metadata, and a 16-bit payload stream with per-byte enables. Pixel unpacking and buffering stages consume that stream.

## Interface
Parameters:
- `MAX_WC`, 16'd2560: largest long-packet word count accepted; larger counts are flagged as errors.

Ports:
- `byte_clk` in 1: byte clock from the MIPI receiver; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: high during an HS burst, starting with the first packet byte. Low means LP state / end of burst.
- `lane0_byte` in 8: even-indexed packet byte (0, 2, 4, …).
- `lane1_byte` in 8: odd-indexed packet byte (1, 3, 5, …).
- `px_data` out 16: payload; [7:0] is the even byte, [15:8] the odd byte.
- `px_be` out 2: byte enables for `px_data`; 2'b00 when there is no payload.
- `frame_start` out 1: 1-cycle pulse on short packet DT=0x00.
- `frame_end` out 1: 1-cycle pulse on DT=0x01.
- `line_start` out 1: 1-cycle pulse on DT=0x02.
- `line_end` out 1: 1-cycle pulse on DT=0x03.
- `pkt_start` out 1: 1-cycle pulse when a long packet header is accepted.
- `pkt_end` out 1: 1-cycle pulse when the last CRC byte of a long packet is consumed.
- `vc` out 2: virtual channel of the last header, DI[7:6].
- `data_type` out 6: DI[5:0] of the last header.
- `word_count` out 16: WC of the last header, also the short-packet data field.
- `line_count` out 16: long packets accepted since the last `frame_start`.
- `pkt_err` out 1: 1-cycle pulse on a protocol error.

## Operation
Header format: DI, WC_lo, WC_hi and ECC arrive over two input cycles.
- Cycle H0: lane0 = DI, lane1 = WC_lo.
- Cycle H1: lane0 = WC_hi, lane1 = ECC. The ECC byte is ignored.
- DT < 0x10 is a short packet; DT >= 0x10 is a long packet.

State machine:
- IDLE: wait for `in_valid`=1, capture DI and WC_lo, go to HDR.
- HDR: capture WC_hi and latch `vc`, `data_type`, `word_count`.
  - Short packet: pulse the matching strobe (DT 0x00–0x03; other short DTs only update metadata), go to WAIT_LP.
  - Long packet with WC > `MAX_WC`: pulse `pkt_err`, go to WAIT_LP.
  - Other long packets: pulse `pkt_start`, increment `line_count`, load `rem` = WC + 2, go to PAYLOAD.
- PAYLOAD: consume 2 bytes per cycle; the first `word_count` bytes are payload, the final 2 are CRC.
  - `rem` >= WC+... expressed per cycle: payload bytes left = `rem` − 2.
  - Payload bytes left >= 2: `px_be`=2'b11.
  - Payload bytes left = 1: `px_be`=2'b01; lane1 carries CRC_lo.
  - Payload bytes left = 0: `px_be`=2'b00 (CRC only).
  - `rem` decrements by 2, saturating at 0. When `rem` <= 2 this cycle, pulse `pkt_end` and go to WAIT_LP. CRC is not checked.
- WAIT_LP: ignore all bytes, including trailer; go to IDLE when `in_valid`=0. One packet per HS burst.
- Abort: `in_valid`=0 while in HDR or PAYLOAD pulses `pkt_err` and returns to IDLE. No `pkt_end` and no further `px_be` are issued.
- WC=0 long packet: `rem`=2, so the first PAYLOAD cycle is pure CRC, with `pkt_end` in the same cycle.
- `frame_start` clears `line_count` to 0. A long packet in the same frame then makes it 1; a clear and an increment never coincide because they come from different packets.
- `line_count` wraps from 16'hFFFF to 0.

## Timing
- All outputs are registered. Latency is exactly 1 cycle from the input cycle to the corresponding output.
- Strobes and `pkt_start` assert in the cycle after input cycle H1. `vc`, `data_type` and `word_count` become valid in that same cycle and hold until the next header.
- The first `px_be`≠0 appears in the cycle after the first PAYLOAD input cycle. Payload words are contiguous with no gaps.
- `pkt_end` coincides with the output cycle of the final CRC input cycle.
- Reset (any cycle, including mid-packet) sets:
  - state to IDLE;
  - `px_data`=0 and `px_be`=0;
  - all pulses to 0;
  - `vc`, `data_type`, `word_count` and `line_count` to 0.
- The first packet is accepted on the first `in_valid`=1 cycle after `reset` deasserts.

## Test plan
- Short FS: bytes 00,05,00,xx, then `in_valid` falls → `frame_start` one cycle after H1, `word_count`=0x0005, `line_count`=0, no `px_be`.
- Long RAW8, DI=0x2A, WC=4, payload 11,22,33,44, CRC AA,BB → `pkt_start`; `px_data`=0x2211 then 0x4433 with `px_be`=11,11; then `pkt_end` with `px_be`=00; `line_count`=1; `data_type`=0x2A.
- Odd WC=3, payload 11,22,33 + CRC → `px_be` sequence 11,01 with the second word's low byte=0x33. `pkt_end` lands on the CRC_hi cycle.
- WC=0x1000 > `MAX_WC` → `pkt_err` pulse, no `px_be`, ignored until `in_valid`=0, then the next FS is parsed normally.
- `in_valid` drops after 1 payload cycle of WC=8 → `pkt_err`, no `pkt_end`, state IDLE; a following LS packet pulses `line_start`.
- `reset` asserted mid-payload, plus `vc` check: all outputs return to 0 the next cycle. A following header with DI=0xC1 gives `vc`=3, `frame_end` pulse.
